uart_rx_core: RTL
=================

# uart_rx_core

Serial receive front end for the Wishbone UART. Synchronises the asynchronous `rx` pin, detects and validates start bits, samples 8 data bits LSB-first at mid-bit, checks the stop bit, and presents each received byte in a holding register with sticky status flags. The Wishbone UART register block reads `rx_data` and the flags and pulses `rd_ack` when software consumes the byte.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `rd_ack`  in  1  one-cycle pulse from the register block: byte consumed, clear flags.
- `rx_data`  out  8  last completed byte; reset 0x00.
- `rx_ready`  out  1  sticky: unread byte in `rx_data`; reset 0.
- `frame_err`  out  1  sticky: stop bit sampled 0; reset 0.
- `overrun`  out  1  sticky: byte completed while `rx_ready`=1; reset 0.
- `parity_err`  out  1  sticky: parity mismatch; reset 0; tied 0 when parity is compiled out.
- `busy`  out  1  high in any state other than IDLE; reset 0.

## Operation
- `rx` passes through two flops (reset value 1) to give `rx_s`. No other logic uses raw `rx`.
- HALF = CLKS_PER_BIT/2. The bit counter is $clog2(CLKS_PER_BIT) bits wide and is cleared on every state transition.
- States:
  - IDLE: `rx_s`=0 → START.
  - START: at count HALF-1, sample `rx_s`. If 0 → DATA. If 1 (glitch) → IDLE with no flag change.
  - DATA: at count CLKS_PER_BIT-1, shift `rx_s` into bit[7] of the shift register (LSB first). After the 8th sample → PARITY if enabled, else STOP.
  - PARITY: at count CLKS_PER_BIT-1, sample the parity bit → STOP.
  - STOP: at count CLKS_PER_BIT-1, sample `rx_s`.
    - 1 → complete the byte and go to IDLE.
    - 0 → set `frame_err`, do not load `rx_data`, go to BREAK.
  - BREAK: stay until `rx_s`=1 → IDLE. A held-low line produces exactly one `frame_err`.
- Completion updates: load `rx_data` from the shift register and set `rx_ready`. If `rx_ready` was already 1 and `rd_ack` is not asserted in the same cycle, set `overrun`; the new byte overwrites the old one.
- `rd_ack` clears `rx_ready`, `frame_err`, `overrun` and `parity_err`. If a completion and `rd_ack` occur in the same cycle, the completion wins: `rx_ready`=1, `rx_data` holds the new byte, and no overrun is flagged. The same rule applies to a simultaneous error and `rd_ack`: the new error flag is set.
- `rd_ack` outside these cases has no effect on the FSM.
- Reset mid-frame: all outputs return to their reset values immediately and the FSM returns to IDLE. The partial frame is discarded.

## Timing
- Edge 0 is the first clock edge that captures `rx`=0 into sync flop 1. `rx_s` is low after edge 1; the FSM enters START at edge 2.
- The start sample occurs at edge 2+HALF. Data bit n (n = 0..7) is sampled at edge 2+HALF+(n+1)·CLKS_PER_BIT.
- The stop bit is sampled at edge 2+HALF+9·CLKS_PER_BIT (add CLKS_PER_BIT with parity). `rx_ready`, `rx_data` and `frame_err` are valid immediately after that edge.
- Back-to-back frames: the FSM is in IDLE one cycle after the stop sample, so the next start edge is accepted with no dead time beyond the 2-cycle synchroniser.
- Flags respond to `rd_ack` on the same edge: low in the following cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in; the frame is 8 data bits + even parity + 1 stop.
  - A mismatch sets `parity_err`. The byte is still loaded and `rx_ready` still set.
- Not defined:
  - The frame is 8N1 with no PARITY state.
  - `parity_err` is constant 0.

## Test plan
- Reset then idle: `rx`=1 for 100 cycles → all outputs 0, `busy`=0.
- CLKS_PER_BIT=4, drive 8N1 frame 0x66 → `rx_ready`=1 at edge 2+2+36, `rx_data`=0x66, no errors. Pulse `rd_ack` → `rx_ready`=0 next cycle.
- Glitch: `rx` low for 1 bit-quarter (1 cycle at CLKS_PER_BIT=4), then high → FSM returns to IDLE, no flags, `rx_data` unchanged.
- Two frames 0x55 then 0xA3 with no `rd_ack` → `rx_data`=0xA3, `overrun`=1, `rx_ready`=1. Repeat with `rd_ack` on the exact completion edge of 0xA3 → `overrun`=0, `rx_ready`=1.
- Frame 0x3C with stop bit 0, then line held low 40 cycles → `frame_err`=1 once, `rx_data` unchanged, FSM stays in BREAK until `rx`=1. A following valid 0x01 frame is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `parity_err`=0. 0x07 with parity bit 0 → `parity_err`=1, `rx_data`=0x07. Assert `rst` mid-data → all outputs 0, next frame received cleanly.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core -- serial receive front end for the Wishbone UART.
//
// Synchronises rx, validates the start bit at mid-bit, samples 8 data bits
// LSB first at mid-bit and checks the stop bit. Each good byte lands in a
// holding register with sticky status flags, which rd_ack clears.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames
// (even parity bit between data and stop). Without it frames are 8N1 and
// parity_err is constant 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   asynchronous serial input, idle high
//   rd_ack     in   one-cycle pulse: byte consumed, clear flags
//   rx_data    out  [7:0] last completed byte
//   rx_ready   out  sticky: unread byte in rx_data
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: byte completed while rx_ready was set
//   parity_err out  sticky: parity mismatch (0 when parity compiled out)
//   busy       out  receiver is not idle
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchroniser, idle-high reset so no false start after reset.
  logic rx_meta_q, rx_s_q;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_ready_q, rx_ready_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic           busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic           par_bit_q, par_bit_d;
  logic           parity_err_q, parity_err_d;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = bit_end ? '0 : cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_ready_d  = rx_ready_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif

    // Clear first so that a completion or error in the same cycle wins.
    if (rd_ack) begin
      rx_ready_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF_M1) begin
          // High at mid-start means a glitch: drop it silently.
          state_d   = rx_s_q ? S_IDLE : S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_ready_d = 1'b1;
            if (rx_ready_q && !rd_ack) overrun_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if (^{shift_q, par_bit_q}) parity_err_d = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it yields only one frame error.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || state_q == S_IDLE || state_q == S_BREAK)
      cnt_d = '0;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_ready  = rx_ready_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
